code_filter: RTL and testbench
==============================

CODE_FILTER -- requirements
Module: code_filter

Interface
REQ-001 Parameter LOG2N, default 3: window length is 2^LOG2N samples; legal range 1..4.
REQ-002 clk  input  1  system clock, 10 MHz nominal.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 done_i  input  1  conversion-done level from the upstream SAR controller; a sample is taken on each 0->1 transition.
REQ-005 ib_i  input  8  coarse bias code from the upstream SAR controller.
REQ-006 ibf_i  input  8  fine bias code from the upstream SAR controller.
REQ-007 clear_i  input  1  synchronous clear of the window and the overrun flag.
REQ-008 ready_i  input  1  downstream accepts the result.
REQ-009 valid_o  output  1  result available.
REQ-010 avg_o  output  8  rounded mean of ibf over the window.
REQ-011 coarse_o  output  8  ib code shared by all samples in the window.
REQ-012 span_o  output  8  max(ibf) - min(ibf) within the window.
REQ-013 overrun_o  output  1  sticky flag: a completed result was dropped.

Function
REQ-014 done_i SHALL be registered (done_q); strobe stb = done_i & ~done_q, one cycle wide; no other sampling.
REQ-015 done_q SHALL reset to 1, so a done_i held high through reset produces no strobe.
REQ-016 Window state SHALL be: acc (8+LOG2N bits), cnt (LOG2N+1 bits), ib_ref (8), mn (8), mx (8).
REQ-017 On stb with cnt==0: acc=ibf_i, mn=mx=ibf_i, ib_ref=ib_i, cnt=1.
REQ-018 On stb with cnt>0 and ib_i==ib_ref: acc+=ibf_i, mn=min(mn,ibf_i), mx=max(mx,ibf_i), cnt+=1.
REQ-019 On stb with cnt>0 and ib_i!=ib_ref: window restarts exactly as in REQ-017 (old samples discarded, no result).
REQ-020 When a REQ-018 update brings cnt to 2^LOG2N: a result SHALL be formed from the updated values, and the window SHALL clear to cnt=0 in the same cycle.
REQ-021 The result SHALL be avg = (acc + 2^(LOG2N-1)) >> LOG2N, using full-width arithmetic with no overflow; span = mx-mn; coarse = ib_ref.
REQ-022 Result latency: valid_o SHALL rise in the cycle after the stb that completes the window.
REQ-023 Output register SHALL be a single entry; avg_o, coarse_o and span_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-024 Transfer SHALL occur when valid_o & ready_i; valid_o falls the next cycle unless a new result loads in the same cycle.
REQ-025 A new result arriving while valid_o=1 and ready_i=0 SHALL be dropped, with overrun_o set (sticky); the held result is unchanged.
REQ-026 A new result arriving in the same cycle as a transfer SHALL load, with valid_o remaining 1 and overrun_o unchanged.
REQ-027 clear_i SHALL zero cnt, acc, mn, mx and overrun_o; the output register and valid_o are unaffected.
REQ-028 clear_i coincident with stb: clear wins, and the sample is discarded.
REQ-029 ready_i while valid_o=0 SHALL have no effect.

Reset
REQ-030 On reset assertion, asynchronously: valid_o=0, avg_o=0, coarse_o=0, span_o=0, overrun_o=0, cnt=0, acc=0, mn=mx=ib_ref=0, done_q=1.
REQ-031 Reset mid-window SHALL discard the partial window; the first full window after release SHALL need 2^LOG2N fresh strobes.
REQ-032 After reset deasserts, the block SHALL sample from the first clock edge; no extra synchronizer stage.

Verification (LOG2N=3)
REQ-033 Eight strobes with ib_i=0x80 and ibf_i=0x40..0x47 -> valid_o=1 one cycle after the 8th strobe; avg_o=0x44 (sum 0x21C, plus 4, >>3); span_o=0x07; coarse_o=0x80.
REQ-034 Four strobes at ib_i=0x80, then eight at ib_i=0x90 with ibf_i=0xFF -> exactly one result: avg_o=0xFF, span_o=0, coarse_o=0x90.
REQ-035 Two windows complete with ready_i=0 -> the first result is held unchanged and overrun_o=1; after ready_i=1 for one cycle, valid_o=0; after clear_i, overrun_o=0.
REQ-036 ready_i=1 in the same cycle a second window completes -> the second result loads, valid_o stays 1, overrun_o=0.
REQ-037 done_i held high for 5 cycles -> a single sample; done_i high during and after reset -> no sample until done_i falls and rises again.
REQ-038 Reset asserted after 5 samples, then 8 new samples -> the result reflects only the 8 new samples; all outputs are 0 during reset.

Source files
------------

// File: rtl/code_filter.sv
// Windowed filter for SAR bias codes: averages 2^LOG2N fine codes that share one coarse code
// and reports mean, coarse code and spread through a single-entry valid/ready output register.
module code_filter #(
    parameter int unsigned LOG2N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_i,
    input  logic [7:0] ib_i,
    input  logic [7:0] ibf_i,
    input  logic       clear_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] avg_o,
    output logic [7:0] coarse_o,
    output logic [7:0] span_o,
    output logic       overrun_o
);
    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned AW = 8 + LOG2N;
    localparam int unsigned CW = LOG2N + 1;

    logic          done_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ib_ref_q, ib_ref_d, mn_q, mn_d, mx_q, mx_d;
    logic          valid_q, valid_d, ovr_q, ovr_d;
    logic [7:0]    avg_q, avg_d, coarse_q, coarse_d, span_q, span_d;

    logic          stb, same_ib, win_done;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    mn_new, mx_new;
    logic [AW:0]   avg_wide, avg_shift;

    assign stb      = done_i & ~done_q;
    assign same_ib  = (cnt_q != '0) && (ib_i == ib_ref_q);
    assign acc_sum  = acc_q + AW'(ibf_i);
    assign cnt_inc  = cnt_q + CW'(1);
    assign mn_new   = (ibf_i < mn_q) ? ibf_i : mn_q;
    assign mx_new   = (ibf_i > mx_q) ? ibf_i : mx_q;
    assign win_done = stb & ~clear_i & same_ib & (cnt_inc == CW'(N));
    // One extra bit so the rounding constant can never wrap the full-window sum.
    assign avg_wide  = {1'b0, acc_sum} + (AW+1)'(N / 2);
    assign avg_shift = avg_wide >> LOG2N;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ib_ref_d = ib_ref_q;
        mn_d     = mn_q;
        mx_d     = mx_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        avg_d    = avg_q;
        coarse_d = coarse_q;
        span_d   = span_q;

        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
            mn_d  = '0;
            mx_d  = '0;
            ovr_d = 1'b0;
        end else if (stb) begin
            if (same_ib) begin
                acc_d = acc_sum;
                mn_d  = mn_new;
                mx_d  = mx_new;
                cnt_d = win_done ? '0 : cnt_inc;
            end else begin
                acc_d    = AW'(ibf_i);
                mn_d     = ibf_i;
                mx_d     = ibf_i;
                ib_ref_d = ib_i;
                cnt_d    = CW'(1);
            end
        end

        // A result loads if the slot is empty or being drained this cycle; otherwise it is lost.
        if (win_done) begin
            if (!valid_q || ready_i) begin
                valid_d  = 1'b1;
                avg_d    = avg_shift[7:0];
                coarse_d = ib_ref_q;
                span_d   = mx_new - mn_new;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            ib_ref_q <= '0;
            mn_q     <= '0;
            mx_q     <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            avg_q    <= '0;
            coarse_q <= '0;
            span_q   <= '0;
        end else begin
            done_q   <= done_i;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ib_ref_q <= ib_ref_d;
            mn_q     <= mn_d;
            mx_q     <= mx_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            avg_q    <= avg_d;
            coarse_q <= coarse_d;
            span_q   <= span_d;
        end
    end

    assign valid_o   = valid_q;
    assign avg_o     = avg_q;
    assign coarse_o  = coarse_q;
    assign span_o    = span_q;
    assign overrun_o = ovr_q;
endmodule

// File: tb/tb_code_filter.sv
// Self-checking bench for code_filter: directed scenarios plus randomized traffic against a
// sample-queue reference model of the window and the single-entry output slot.
module tb_code_filter;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done_r = 1'b0, clr_r = 1'b0, rdy_r = 1'b0;
    logic [7:0] ib_r = '0, ibf_r = '0;
    logic       valid_w, ovr_w;
    logic [7:0] avg_w, coarse_w, span_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int  m_win[$];
    int  m_ref;
    bit  m_prev_done;
    bit  m_valid, m_ovr;
    int  m_avg, m_coarse, m_span;

    code_filter #(.LOG2N(LOG2N)) dut (
        .clk      (clk),
        .reset    (rst),
        .done_i   (done_r),
        .ib_i     (ib_r),
        .ibf_i    (ibf_r),
        .clear_i  (clr_r),
        .ready_i  (rdy_r),
        .valid_o  (valid_w),
        .avg_o    (avg_w),
        .coarse_o (coarse_w),
        .span_o   (span_w),
        .overrun_o(ovr_w)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_ref = 0; m_prev_done = 1'b1;
        m_valid = 1'b0; m_ovr = 1'b0;
        m_avg = 0; m_coarse = 0; m_span = 0;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit stb, res;
        int sum, mn, mx, r_avg, r_span;
        stb = done_r && !m_prev_done;
        m_prev_done = done_r;
        res = 1'b0;
        if (clr_r) begin
            m_win.delete();
            m_ovr = 1'b0;
        end else if (stb) begin
            if (m_win.size() == 0 || int'(ib_r) != m_ref) begin
                m_win.delete();
                m_win.push_back(int'(ibf_r));
                m_ref = int'(ib_r);
            end else begin
                m_win.push_back(int'(ibf_r));
                if (m_win.size() == N) begin
                    sum = 0; mn = 255; mx = 0;
                    foreach (m_win[k]) begin
                        sum += m_win[k];
                        if (m_win[k] < mn) mn = m_win[k];
                        if (m_win[k] > mx) mx = m_win[k];
                    end
                    r_avg  = (sum + N / 2) / N;
                    r_span = mx - mn;
                    res = 1'b1;
                    m_win.delete();
                end
            end
        end
        if (res) begin
            if (!m_valid || rdy_r) begin
                m_valid = 1'b1; m_avg = r_avg; m_span = r_span; m_coarse = m_ref;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy_r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},   int'(valid_w),  int'(m_valid));
        check({tag, ".overrun"}, int'(ovr_w),    int'(m_ovr));
        check({tag, ".avg"},     int'(avg_w),    m_avg);
        check({tag, ".coarse"},  int'(coarse_w), m_coarse);
        check({tag, ".span"},    int'(span_w),   m_span);
    endtask

    task automatic cycle(input string tag, input bit d, input logic [7:0] ib, input logic [7:0] ibf,
                         input bit clr, input bit rdy);
        done_r = d; ib_r = ib; ibf_r = ibf; clr_r = clr; rdy_r = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic strobe(input string tag, input logic [7:0] ib, input logic [7:0] ibf, input bit rdy);
        cycle(tag, 1'b0, ib, ibf, 1'b0, rdy);
        cycle(tag, 1'b1, ib, ibf, 1'b0, rdy);
    endtask

    task automatic do_reset(input bit d);
        done_r = d;
        #1 rst = 1'b1;
        #1;
        check("rst.valid",   int'(valid_w),  0);
        check("rst.avg",     int'(avg_w),    0);
        check("rst.coarse",  int'(coarse_w), 0);
        check("rst.span",    int'(span_w),   0);
        check("rst.overrun", int'(ovr_w),    0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);

        // Eight ascending fine codes at one coarse code
        for (int i = 0; i < N; i++) strobe("ramp", 8'h80, 8'(8'h40 + i), 1'b0);
        check("ramp.valid", int'(valid_w), 1);
        check("ramp.avg", int'(avg_w), 8'h44);
        check("ramp.span", int'(span_w), 8'h07);
        check("ramp.coarse", int'(coarse_w), 8'h80);
        cycle("ramp.drain", 1'b0, 8'h80, 8'h00, 1'b0, 1'b1);
        check("ramp.drained", int'(valid_w), 0);

        // Coarse code change restarts the window; only one result
        for (int i = 0; i < 4; i++) strobe("restart", 8'h80, 8'h10, 1'b1);
        for (int i = 0; i < N; i++) strobe("restart", 8'h90, 8'hFF, 1'b0);
        check("restart.avg", int'(avg_w), 8'hFF);
        check("restart.span", int'(span_w), 0);
        check("restart.coarse", int'(coarse_w), 8'h90);
        cycle("restart.drain", 1'b0, 8'h90, 8'h00, 1'b0, 1'b1);

        // Two windows without ready: first held, overrun set, then drain and clear
        for (int i = 0; i < N; i++) strobe("ovr.w1", 8'h20, 8'(i * 3), 1'b0);
        for (int i = 0; i < N; i++) strobe("ovr.w2", 8'h21, 8'hC0, 1'b0);
        check("ovr.flag", int'(ovr_w), 1);
        check("ovr.held_coarse", int'(coarse_w), 8'h20);
        check("ovr.held_span", int'(span_w), 21);
        cycle("ovr.drain", 1'b0, 8'h21, 8'h00, 1'b0, 1'b1);
        check("ovr.drained", int'(valid_w), 0);
        cycle("ovr.clear", 1'b0, 8'h21, 8'h00, 1'b1, 1'b0);
        check("ovr.cleared", int'(ovr_w), 0);

        // Result arriving during a transfer loads without overrun
        for (int i = 0; i < N; i++) strobe("xfer.w1", 8'h33, 8'h01, 1'b0);
        for (int i = 0; i < N - 1; i++) strobe("xfer.w2", 8'h33, 8'h09, 1'b0);
        cycle("xfer.w2", 1'b0, 8'h33, 8'h09, 1'b0, 1'b0);
        cycle("xfer.last", 1'b1, 8'h33, 8'h09, 1'b0, 1'b1);
        check("xfer.valid", int'(valid_w), 1);
        check("xfer.avg", int'(avg_w), 8'h09);
        check("xfer.overrun", int'(ovr_w), 0);
        cycle("xfer.drain", 1'b0, 8'h33, 8'h00, 1'b0, 1'b1);

        // Partial window discarded by reset; done held high across reset gives no sample
        for (int i = 0; i < 5; i++) strobe("rstmid", 8'h55, 8'hAA, 1'b1);
        cycle("rstmid.hi", 1'b1, 8'h55, 8'hAA, 1'b0, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 8'h55, 8'h11, 1'b0, 1'b1);
        for (int i = 0; i < N - 1; i++) begin
            strobe("fresh", 8'h56, 8'h10, 1'b1);
            if (i == 1) for (int k = 0; k < 4; k++) cycle("long_hi", 1'b1, 8'h56, 8'h77, 1'b0, 1'b1);
        end
        check("fresh.pending", int'(valid_w), 0);
        strobe("fresh", 8'h56, 8'h18, 1'b0);
        check("fresh.valid", int'(valid_w), 1);
        check("fresh.avg", int'(avg_w), 8'h11);
        check("fresh.coarse", int'(coarse_w), 8'h56);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
            cycle("rand", 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 11) == 0) ? 8'h81 : 8'h80,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
